// File: rtl/bram_access_pkg.sv
// Shared encodings for the BRAM access controller: request sizes, FSM states and byte-lane masks.
// Optional misaligned-access trapping is enabled with `define BRAM_ACCESS_MISALIGN_TRAP_EN.
package bram_access_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_RD_WAIT = 2'b01,
        ST_MERGE   = 2'b10,
        ST_RESP    = 2'b11
    } state_e;

    localparam logic [3:0] LANES_BYTE = 4'b0001;
    localparam logic [3:0] LANES_HALF = 4'b0011;
    localparam logic [3:0] LANES_WORD = 4'b1111;

    // Size encoding 2'b11 behaves exactly like a word.
    function automatic logic [3:0] lane_sel(input logic [1:0] size, input logic [1:0] off);
        logic [3:0] lanes;
        case (size)
            SZ_BYTE: lanes = LANES_BYTE << off;
            SZ_HALF: lanes = LANES_HALF << {off[1], 1'b0};
            default: lanes = LANES_WORD;
        endcase
        return lanes;
    endfunction

    function automatic logic [31:0] lane_bits(input logic [3:0] lanes);
        return {{8{lanes[3]}}, {8{lanes[2]}}, {8{lanes[1]}}, {8{lanes[0]}}};
    endfunction

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
        logic mis;
        case (size)
            SZ_BYTE: mis = 1'b0;
            SZ_HALF: mis = off[0];
            default: mis = (off != 2'b00);
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/bram_lane_unit.sv
// Combinational byte-lane datapath: load extraction with sign/zero extension and
// read-modify-write merge of sub-word store data into a BRAM word.
module bram_lane_unit
    import bram_access_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic [1:0]  off_i,
    input  logic        unsigned_i,
    input  logic [31:0] rdata_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] load_o,
    output logic [31:0] merge_o
);

    logic [4:0]  shamt_s;
    logic [31:0] shifted_s;
    logic [31:0] mask_s;
    logic [31:0] wshift_s;

    // Align the addressed lanes to bit 0 for loads and the store data to its lanes for merges.
    always_comb begin
        shamt_s   = {off_i, 3'b000};
        shifted_s = rdata_i >> shamt_s;
        mask_s    = lane_bits(lane_sel(size_i, off_i));
        wshift_s  = wdata_i << shamt_s;
        case (size_i)
            SZ_BYTE: load_o = {{24{~unsigned_i & shifted_s[7]}}, shifted_s[7:0]};
            SZ_HALF: load_o = {{16{~unsigned_i & shifted_s[15]}}, shifted_s[15:0]};
            default: load_o = rdata_i;
        endcase
        merge_o = (rdata_i & ~mask_s) | (wshift_s & mask_s);
    end

endmodule

// File: rtl/bram_access_ctrl.sv
// Initiator for a single-port 1-cycle-read BRAM: byte/half/word loads and stores, sub-word stores via RMW.
// Define BRAM_ACCESS_MISALIGN_TRAP_EN to answer misaligned requests with rsp_err instead of forcing alignment.
module bram_access_ctrl
    import bram_access_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [31:0]           req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [31:0]           rsp_rdata,
    output logic                  rsp_err,
    output logic                  mem_ce,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_din,
    input  logic [DATA_WIDTH-1:0] mem_dout
);

    state_e                  state_q, state_d;
    logic                    unsigned_q, unsigned_d;
    logic [1:0]              size_q, size_d;
    logic [1:0]              off_q, off_d;
    logic [ADDR_WIDTH-1:0]   waddr_q, waddr_d;
    logic [31:0]             wdata_q, wdata_d;
    logic [31:0]             rdata_q, rdata_d;
    logic                    err_q, err_d;
    logic [ADDR_WIDTH-1:0]   mem_addr_q;
    logic [DATA_WIDTH-1:0]   mem_din_q;

    logic                    ce_s, we_s, ready_s, misalign_s;
    logic [1:0]              req_off_s;
    logic [ADDR_WIDTH-1:0]   addr_s;
    logic [DATA_WIDTH-1:0]   din_s;
    logic [31:0]             load_s, merge_s;
    logic                    unused_s;

    assign unused_s = ^req_addr[31:ADDR_WIDTH+2];

    // Forced alignment: halves drop off[0], words drop both offset bits.
    always_comb begin
        case (req_size)
            SZ_BYTE: req_off_s = req_addr[1:0];
            SZ_HALF: req_off_s = {req_addr[1], 1'b0};
            default: req_off_s = 2'b00;
        endcase
`ifdef BRAM_ACCESS_MISALIGN_TRAP_EN
        misalign_s = is_misaligned(req_size, req_addr[1:0]);
`else
        misalign_s = 1'b0;
`endif
    end

    bram_lane_unit u_lane (
        .size_i     (size_q),
        .off_i      (off_q),
        .unsigned_i (unsigned_q),
        .rdata_i    (mem_dout),
        .wdata_i    (wdata_q),
        .load_o     (load_s),
        .merge_o    (merge_s)
    );

    // Next-state, request latching and BRAM issue decode.
    always_comb begin
        state_d    = state_q;
        unsigned_d = unsigned_q;
        size_d     = size_q;
        off_d      = off_q;
        waddr_d    = waddr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        err_d      = err_q;
        ce_s       = 1'b0;
        we_s       = 1'b0;
        ready_s    = 1'b0;
        addr_s     = mem_addr_q;
        din_s      = mem_din_q;
        case (state_q)
            ST_IDLE: begin
                ready_s = 1'b1;
                if (req_valid) begin
                    unsigned_d = req_unsigned;
                    size_d     = req_size;
                    off_d      = req_off_s;
                    waddr_d    = req_addr[ADDR_WIDTH+1:2];
                    wdata_d    = req_wdata;
                    rdata_d    = 32'h0000_0000;
                    err_d      = 1'b0;
                    if (misalign_s) begin
                        err_d   = 1'b1;
                        state_d = ST_RESP;
                    end else if (req_we && req_size[1]) begin
                        ce_s    = 1'b1;
                        we_s    = 1'b1;
                        addr_s  = req_addr[ADDR_WIDTH+1:2];
                        din_s   = req_wdata;
                        state_d = ST_RESP;
                    end else if (req_we) begin
                        ce_s    = 1'b1;
                        addr_s  = req_addr[ADDR_WIDTH+1:2];
                        state_d = ST_MERGE;
                    end else begin
                        ce_s    = 1'b1;
                        addr_s  = req_addr[ADDR_WIDTH+1:2];
                        state_d = ST_RD_WAIT;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RD_WAIT: begin
                rdata_d = load_s;
                state_d = ST_RESP;
            end
            ST_MERGE: begin
                ce_s    = 1'b1;
                we_s    = 1'b1;
                addr_s  = waddr_q;
                din_s   = merge_s;
                state_d = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RESP;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Reset gates the strobes so an abandoned MERGE never writes.
    assign mem_ce    = ce_s & ~rst;
    assign mem_we    = we_s & ~rst;
    assign req_ready = ready_s & ~rst;
    assign mem_addr  = addr_s;
    assign mem_din   = din_s;
    assign rsp_valid = (state_q == ST_RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

    // State, latched request, response and held BRAM address/data registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            unsigned_q <= 1'b0;
            size_q     <= 2'b00;
            off_q      <= 2'b00;
            waddr_q    <= '0;
            wdata_q    <= 32'h0000_0000;
            rdata_q    <= 32'h0000_0000;
            err_q      <= 1'b0;
            mem_addr_q <= '0;
            mem_din_q  <= '0;
        end else begin
            state_q    <= state_d;
            unsigned_q <= unsigned_d;
            size_q     <= size_d;
            off_q      <= off_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            err_q      <= err_d;
            mem_addr_q <= addr_s;
            mem_din_q  <= din_s;
        end
    end

endmodule

// File: tb/tb_bram_access_ctrl.sv
// Directed self-checking bench for bram_access_ctrl with a behavioural 1-cycle-read BRAM.
module tb_bram_access_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'b10;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        mem_ce, mem_we;
    logic [9:0]  mem_addr;
    logic [31:0] mem_din;
    logic [31:0] mem_dout = 32'h0;

    logic [31:0] mem [0:1023];
    logic [31:0] last_din = 32'h0;
    int          ce_cnt = 0;
    int          we_cnt = 0;
    int          n_tests = 0;
    int          n_fail = 0;

    bram_access_ctrl #(.ADDR_WIDTH(10), .DATA_WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .mem_ce(mem_ce), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_ce) begin
            if (mem_we) begin
                mem[mem_addr] <= mem_din;
                last_din      <= mem_din;
            end
            mem_dout <= mem[mem_addr];
        end
    end

    always @(negedge clk) begin
        if (mem_ce) ce_cnt++;
        if (mem_ce && mem_we) we_cnt++;
    end

    // Issue one request; returns at the negedge where rsp_valid is first seen.
    task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          output int lat, output int ces, output int wes,
                          output logic [31:0] rdata, output logic err, output logic tmo);
        int  ce0, we0;
        logic got;
        ce0 = ce_cnt; we0 = we_cnt; tmo = 1'b0; lat = 0;
        req_we = we; req_size = size; req_unsigned = uns; req_addr = addr; req_wdata = wdata;
        req_valid = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (req_ready) got = 1'b1;
        end
        if (!got) tmo = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            lat++;
            if (rsp_valid) got = 1'b1;
        end
        if (!got) tmo = 1'b1;
        rdata = rsp_rdata; err = rsp_err;
        ces = ce_cnt - ce0; wes = we_cnt - we0;
    endtask

    task automatic retire();
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h10;
        @(negedge clk); @(negedge clk);
        n_tests++; if (mem_ce !== 1'b0) begin n_fail++; $display("FAIL reset_ce: got %b want 0", mem_ce); end
        n_tests++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b want 0", req_ready); end
        n_tests++; if (rsp_valid !== 1'b0 || rsp_rdata !== 32'h0 || rsp_err !== 1'b0) begin
            n_fail++; $display("FAIL reset_rsp: got v=%b d=%h e=%b want 0/0/0", rsp_valid, rsp_rdata, rsp_err); end
        req_valid = 1'b0;
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk);
        n_tests++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_release_ready: got %b want 1", req_ready); end
        retire();
    endtask

    task automatic test_load_word();
        int lat, ces, wes; logic [31:0] rd; logic er, tmo;
        mem[4] = 32'hDEADBEEF;
        do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, lat, ces, wes, rd, er, tmo);
        n_tests++; if (tmo !== 1'b0) begin n_fail++; $display("FAIL lw_timeout: got %b want 0", tmo); end
        n_tests++; if (rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL lw_data: got %h want deadbeef", rd); end
        n_tests++; if (lat != 2) begin n_fail++; $display("FAIL lw_latency: got %0d want 2", lat); end
        n_tests++; if (ces != 1 || wes != 0) begin n_fail++; $display("FAIL lw_ce: got ce=%0d we=%0d want 1/0", ces, wes); end
        retire();
    endtask

    task automatic test_subword_loads();
        int lat, ces, wes; logic [31:0] rd; logic er, tmo;
        logic [1:0]  sz [4]  = '{2'b00, 2'b00, 2'b01, 2'b01};
        logic        un [4]  = '{1'b0, 1'b1, 1'b0, 1'b1};
        logic [31:0] ad [4]  = '{32'h13, 32'h13, 32'h12, 32'h10};
        logic [31:0] ex [4]  = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF8011, 32'h00002233};
        mem[4] = 32'h80112233;
        for (int i = 0; i < 4; i++) begin
            do_req(1'b0, sz[i], un[i], ad[i], 32'h0, lat, ces, wes, rd, er, tmo);
            n_tests++; if (rd !== ex[i] || tmo !== 1'b0) begin
                n_fail++; $display("FAIL subload_%0d: got %h tmo=%b want %h", i, rd, tmo, ex[i]); end
            retire();
        end
    endtask

    task automatic test_subword_stores();
        int lat, ces, wes; logic [31:0] rd; logic er, tmo;
        mem[8] = 32'h11223344;
        do_req(1'b1, 2'b00, 1'b0, 32'h21, 32'h000000AA, lat, ces, wes, rd, er, tmo);
        n_tests++; if (ces != 2 || wes != 1) begin n_fail++; $display("FAIL sb_cycles: got ce=%0d we=%0d want 2/1", ces, wes); end
        n_tests++; if (last_din !== 32'h1122AA44) begin n_fail++; $display("FAIL sb_din: got %h want 1122aa44", last_din); end
        n_tests++; if (lat != 2 || rd !== 32'h0 || tmo !== 1'b0) begin
            n_fail++; $display("FAIL sb_rsp: got lat=%0d d=%h want 2/0", lat, rd); end
        retire();
        do_req(1'b1, 2'b01, 1'b0, 32'h22, 32'h0000BEEF, lat, ces, wes, rd, er, tmo);
        n_tests++; if (mem[8] !== 32'hBEEFAA44) begin n_fail++; $display("FAIL sh_mem: got %h want beefaa44", mem[8]); end
        retire();
    endtask

    task automatic test_word_store();
        int lat, ces, wes; logic [31:0] rd; logic er, tmo;
        do_req(1'b1, 2'b10, 1'b0, 32'h30, 32'hCAFEF00D, lat, ces, wes, rd, er, tmo);
        n_tests++; if (ces != 1 || wes != 1) begin n_fail++; $display("FAIL sw_cycles: got ce=%0d we=%0d want 1/1", ces, wes); end
        n_tests++; if (lat != 1 || tmo !== 1'b0) begin n_fail++; $display("FAIL sw_latency: got %0d want 1", lat); end
        retire();
        do_req(1'b0, 2'b10, 1'b0, 32'h30, 32'h0, lat, ces, wes, rd, er, tmo);
        n_tests++; if (rd !== 32'hCAFEF00D) begin n_fail++; $display("FAIL sw_readback: got %h want cafef00d", rd); end
        retire();
    endtask

    task automatic test_backpressure();
        int lat, ces, wes, ce0; logic [31:0] rd; logic er, tmo;
        rsp_ready = 1'b0;
        do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, lat, ces, wes, rd, er, tmo);
        ce0 = ce_cnt;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); @(negedge clk);
            n_tests++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h80112233 || req_ready !== 1'b0 || mem_ce !== 1'b0) begin
                n_fail++; $display("FAIL bp_hold_%0d: got v=%b d=%h rdy=%b ce=%b want 1/80112233/0/0",
                                   i, rsp_valid, rsp_rdata, req_ready, mem_ce); end
        end
        rsp_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        n_tests++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || ce_cnt != ce0) begin
            n_fail++; $display("FAIL bp_retire: got v=%b rdy=%b ces=%0d want 0/1/0", rsp_valid, req_ready, ce_cnt - ce0); end
        retire();
    endtask

    task automatic test_misalign();
        int lat, ces, wes; logic [31:0] rd; logic er, tmo;
`ifdef BRAM_ACCESS_MISALIGN_TRAP_EN
        do_req(1'b0, 2'b10, 1'b0, 32'h02, 32'h0, lat, ces, wes, rd, er, tmo);
        n_tests++; if (ces != 0) begin n_fail++; $display("FAIL mis_ce: got %0d want 0", ces); end
        n_tests++; if (lat != 1 || er !== 1'b1 || rd !== 32'h0) begin
            n_fail++; $display("FAIL mis_rsp: got lat=%0d err=%b d=%h want 1/1/0", lat, er, rd); end
        retire();
`else
        do_req(1'b0, 2'b10, 1'b0, 32'h12, 32'h0, lat, ces, wes, rd, er, tmo);
        n_tests++; if (rd !== 32'h80112233 || er !== 1'b0) begin
            n_fail++; $display("FAIL align_word: got %h err=%b want 80112233/0", rd, er); end
        retire();
        do_req(1'b0, 2'b01, 1'b0, 32'h13, 32'h0, lat, ces, wes, rd, er, tmo);
        n_tests++; if (rd !== 32'hFFFF8011 || er !== 1'b0) begin
            n_fail++; $display("FAIL align_half: got %h err=%b want ffff8011/0", rd, er); end
        retire();
`endif
    endtask

    task automatic test_reset_merge();
        int we0; logic got;
        we0 = we_cnt;
        req_we = 1'b1; req_size = 2'b01; req_unsigned = 1'b0; req_addr = 32'h20; req_wdata = 32'h1234;
        req_valid = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (req_ready) got = 1'b1;
        end
        n_tests++; if (got !== 1'b1) begin n_fail++; $display("FAIL rm_accept: got %b want 1", got); end
        @(posedge clk); #1;
        req_valid = 1'b0; rst = 1'b1;
        @(negedge clk);
        n_tests++; if (mem_ce !== 1'b0 || mem_we !== 1'b0) begin
            n_fail++; $display("FAIL rm_gate: got ce=%b we=%b want 0/0", mem_ce, mem_we); end
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk);
        n_tests++; if (rsp_valid !== 1'b0 || rsp_rdata !== 32'h0 || rsp_err !== 1'b0 || req_ready !== 1'b1) begin
            n_fail++; $display("FAIL rm_outputs: got v=%b d=%h e=%b rdy=%b want 0/0/0/1", rsp_valid, rsp_rdata, rsp_err, req_ready); end
        n_tests++; if (mem[8] !== 32'hBEEFAA44 || we_cnt != we0) begin
            n_fail++; $display("FAIL rm_mem: got %h writes=%0d want beefaa44/0", mem[8], we_cnt - we0); end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        test_reset();
        test_load_word();
        test_subword_loads();
        test_subword_stores();
        test_word_store();
        test_backpressure();
        test_misalign();
        test_reset_merge();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/bram_access_ctrl.md
Name: bram_access_ctrl

Overview:
- Initiator side of the single-port BRAM interface (ce/we/addr/din/dout, 1-cycle synchronous read).
- Converts byte-addressed core load/store requests (byte/half/word, signed/unsigned) into word-wide BRAM accesses.
- Sub-word stores use read-modify-write. Sits between the RISC-V core's LSU/fetch path and the data/program BRAM.

Parameters:
- ADDR_WIDTH, 10, BRAM word-address width (BRAM depth 2^ADDR_WIDTH).
- DATA_WIDTH, 32, BRAM word width. Only 32 is supported.

Ports:
- clk  in  1  clock, all logic on posedge
- rst  in  1  synchronous reset, active-high
- req_valid  in  1  request valid
- req_ready  out  1  controller can accept a request
- req_we  in  1  1=store, 0=load
- req_size  in  2  00=byte, 01=half, 10=word, 11=treated as word
- req_unsigned  in  1  loads: 1=zero-extend, 0=sign-extend
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-aligned
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response accepted
- rsp_rdata  out  32  load result, extended; 0 for stores
- rsp_err  out  1  misaligned-access flag (see Optional Feature)
- mem_ce  out  1  BRAM chip enable
- mem_we  out  1  BRAM write enable
- mem_addr  out  ADDR_WIDTH  BRAM word address
- mem_din  out  32  BRAM write data
- mem_dout  in  32  BRAM read data, valid the cycle after a read issue

Behaviour:
- States: IDLE, RD_WAIT, MERGE, RESP. Handshakes fire on valid&ready at posedge.
- Addressing:
  - Word address = req_addr[ADDR_WIDTH+1:2]; upper bits are ignored (wrap).
  - off = req_addr[1:0]. Byte uses lane off; half uses lanes 2*off[1]..+1; word uses all lanes.
- IDLE: req_ready=1. mem_* are driven combinationally from req_* in the acceptance cycle.
  - Word store: ce=1, we=1, din=req_wdata. Next state RESP.
  - Load: ce=1, we=0. Next state RD_WAIT.
  - Sub-word store: ce=1, we=0. Next state MERGE.
  - Request fields are latched on acceptance.
- RD_WAIT:
  - Extract lanes from mem_dout, shifted right by 8*offset.
  - Sign- or zero-extend from bit 7 or bit 15; register into rsp_rdata.
  - Next state RESP.
- MERGE:
  - ce=1, we=1, same word address.
  - din = mem_dout with the selected lanes replaced by req_wdata[7:0] or [15:0].
  - Next state RESP.
- RESP: rsp_valid=1, req_ready=0, mem_ce=0.
  - rsp_rdata/rsp_err are held stable until rsp_ready. Then go to IDLE.
  - No request is accepted in the same cycle the response retires.
- Latency from acceptance to rsp_valid: 1 cycle for word stores, 2 cycles for loads and sub-word stores.
- Outside the issue cycles: mem_ce=0, mem_we=0, mem_addr and mem_din hold their last values.
- Reset:
  - State=IDLE; rsp_valid=0, rsp_rdata=0, rsp_err=0; latched request registers=0.
  - mem_ce and mem_we are gated by !rst, so they are 0 while rst is high.
  - Reset mid-operation abandons the transaction. Reset during MERGE performs no write.
  - req_ready=0 while rst is high.

Optional Feature:
- Macro: BRAM_ACCESS_MISALIGN_TRAP_EN.
- Misaligned means a half with off[0]=1, or a word with off!=0.
- Defined:
  - A misaligned request is accepted with no memory access (mem_ce=0).
  - Next cycle is RESP with rsp_err=1 and rsp_rdata=0.
- Undefined:
  - rsp_err is tied 0.
  - Forced alignment: half ignores off[0]; word ignores off[1:0].

Decomposition:
- Package bram_access_pkg holds:
  - size encodings SZ_BYTE/SZ_HALF/SZ_WORD;
  - state encodings;
  - the lane-mask constants.
- Sub-module bram_lane_unit (combinational) holds load extraction/extension and store lane merge; the FSM stays in the top.

Test Plan:
- Load word: mem[4]=0xDEADBEEF; LW addr 0x10 -> exactly one mem_ce (we=0); rsp_valid 2 cycles after accept; rsp_rdata=0xDEADBEEF.
- Sub-word loads: mem[4]=0x80112233.
  - LB addr 0x13 -> 0xFFFFFF80; LBU addr 0x13 -> 0x00000080.
  - LH addr 0x12 -> 0xFFFF8011; LHU addr 0x10 -> 0x00002233.
- Sub-word stores: mem[8]=0x11223344.
  - SB addr 0x21 data 0xAA -> one read cycle then one write cycle with din=0x1122AA44.
  - SH addr 0x22 data 0xBEEF on the result -> mem[8]=0xBEEFAA44.
- Word store: SW addr 0x30 data 0xCAFEF00D -> single ce/we cycle; rsp_valid next cycle; LW readback returns 0xCAFEF00D.
- Backpressure: rsp_ready low for 5 cycles -> rsp_valid stays 1, rsp_rdata stable, req_ready=0, mem_ce=0 throughout; retires on the first rsp_ready=1.
- Reset and misalign:
  - rst asserted during MERGE of SH -> no mem_we pulse, memory unchanged, all outputs reset next cycle.
  - With the macro: LW addr 0x02 -> no mem_ce; rsp_err=1 with rsp_rdata=0 one cycle after accept.
